bpred_bht: RTL and testbench
============================

Name: bpred_bht

Overview:
- Branch history table for the RISC-V core. It is the predict/train counterpart to the execute-stage branch comparator.
- Fetch issues a lookup by PC and receives a registered taken/not-taken prediction.
- Execute returns the resolved outcome, and the block trains a table of 2-bit saturating counters.
- The block also keeps saturating statistics counters for update and mispredict events.

Parameters:
- IDX_BITS, 6, table index width; the table has 2**IDX_BITS entries.
- STAT_BITS, 16, width of each statistics counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- ready  output  1  high when the table is initialised and accepting traffic
- pred_req  input  1  lookup request strobe
- pred_pc  input  32  PC of the instruction being looked up
- pred_rsp_valid  output  1  lookup response valid, one cycle after an accepted pred_req
- pred_taken  output  1  predicted direction (counter MSB)
- pred_idx  output  IDX_BITS  table index used; fetch carries it down the pipe to execute
- upd_valid  input  1  resolved-branch strobe from execute
- upd_idx  input  IDX_BITS  index returned with the branch
- upd_taken  input  1  resolved outcome, i.e. the comparator result
- upd_pred  input  1  prediction that was made for this branch
- stat_upd  output  STAT_BITS  number of accepted updates
- stat_mispred  output  STAT_BITS  number of accepted updates with upd_taken != upd_pred

Behaviour:
- Reset values:
  - ready=0, pred_rsp_valid=0, pred_taken=0, pred_idx=0.
  - stat_upd=0, stat_mispred=0.
  - Init pointer=0, state=INIT.
- FSM state INIT:
  - One entry per cycle is written to 2'b01 (weakly not-taken), at pointer 0 .. 2**IDX_BITS-1.
  - ready=0.
  - pred_req and upd_valid are ignored: no response, no training, no stats change.
  - After the last entry is written, the next state is RUN.
- INIT duration: ready rises exactly 2**IDX_BITS cycles after the first cycle with rst low.
- FSM state RUN: ready=1. rst returns the FSM to INIT from any state, including mid-INIT (pointer restarts at 0); statistics clear.
- Index: idx = pred_pc[IDX_BITS+1:2]. PC bits [1:0] are ignored.
- Lookup:
  - An accepted pred_req in cycle N gives, in cycle N+1: pred_rsp_valid=1, pred_taken = entry[idx][1], pred_idx = idx.
  - pred_rsp_valid is a single-cycle pulse per request.
  - Back-to-back requests give back-to-back responses.
  - When no request was accepted, pred_taken and pred_idx hold their last values.
- Update:
  - If upd_taken=1, entry[upd_idx] increments, saturating at 2'b11.
  - Otherwise it decrements, saturating at 2'b00.
  - The write takes effect at the end of the cycle.
- Same-cycle collision (pred_req and upd_valid to the same index): the response reflects the post-update counter (write-first forwarding).
- Statistics:
  - stat_upd increments on every accepted update.
  - stat_mispred increments when upd_taken != upd_pred.
  - Both saturate at all-ones and never wrap.
- Update and lookup to different indices in the same cycle are fully independent.

Optional Feature:
- Macro BPRED_GSHARE_EN.
- When defined:
  - An IDX_BITS-wide global history register (GHR), reset and INIT value 0, is instantiated.
  - Lookup index = pred_pc[IDX_BITS+1:2] XOR GHR. pred_idx reports this hashed index.
  - On each accepted update, GHR = {GHR[IDX_BITS-2:0], upd_taken}.
  - A lookup in the same cycle as an update uses the pre-shift GHR.
- When undefined: there is no GHR, and indexing is pure PC bimodal as described above.

Test Plan:
- Init timing: deassert rst and count cycles -> ready=1 exactly 64 cycles later (IDX_BITS=6). A lookup of any PC right after ready -> pred_taken=0.
- Training: three updates to idx 5 with upd_taken=1, then look up PC 0x14 -> pred_taken=1. Counter saturates at 11: a further taken update followed by one not-taken update -> still predicts taken (counter 10).
- Saturation low: two not-taken updates to idx 9, then one taken update -> lookup of PC 0x24 predicts 0 (counter 01).
- Collision: idx 3 holds counter 01; in the same cycle, pred_req with PC 0x0C and upd_valid with idx 3, taken=1 -> next cycle pred_taken=1.
- Stats: ten updates, four with upd_pred != upd_taken -> stat_upd=10, stat_mispred=4. Forced saturation with STAT_BITS=4 over 20 updates -> stat_upd=15.
- Reset mid-operation: assert rst during RUN with a trained table -> ready falls the next cycle, stats clear, and after 64 cycles every PC predicts 0.
- With BPRED_GSHARE_EN defined: add a directed case where the GHR shifts in a taken outcome and the lookup index changes accordingly.

Source files
------------

// File: rtl/bpred_bht.sv
// bpred_bht: table of 2-bit saturating counters with a registered lookup port, a training port and saturating event statistics.
// Defining BPRED_GSHARE_EN hashes the lookup index with a global history register (gshare); otherwise indexing is PC bimodal.
module bpred_bht #(
    parameter int IDX_BITS  = 6,
    parameter int STAT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic                 pred_req,
    input  logic [31:0]          pred_pc,
    output logic                 pred_rsp_valid,
    output logic                 pred_taken,
    output logic [IDX_BITS-1:0]  pred_idx,
    input  logic                 upd_valid,
    input  logic [IDX_BITS-1:0]  upd_idx,
    input  logic                 upd_taken,
    input  logic                 upd_pred,
    output logic [STAT_BITS-1:0] stat_upd,
    output logic [STAT_BITS-1:0] stat_mispred
);

    localparam int         DEPTH       = 1 << IDX_BITS;
    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_MAX     = 2'b11;
    localparam logic [1:0] CNT_MIN     = 2'b00;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_BITS-1:0]    init_ptr_q, init_ptr_d;
    logic [1:0]             table_q [DEPTH];

    logic                   rsp_valid_q, rsp_valid_d;
    logic                   pred_taken_q, pred_taken_d;
    logic [IDX_BITS-1:0]    pred_idx_q, pred_idx_d;
    logic [STAT_BITS-1:0]   stat_upd_q, stat_upd_d;
    logic [STAT_BITS-1:0]   stat_mispred_q, stat_mispred_d;

    logic                   run;
    logic                   lkp_accept;
    logic                   upd_accept;
    logic [IDX_BITS-1:0]    pc_idx;
    logic [IDX_BITS-1:0]    lkp_idx;
    logic [1:0]             upd_cur;
    logic [1:0]             upd_new;
    logic [1:0]             lkp_cnt;

    logic                   tbl_we;
    logic [IDX_BITS-1:0]    tbl_widx;
    logic [1:0]             tbl_wdata;

    logic                   unused_pc;

    assign run        = (state_q == ST_RUN);
    assign lkp_accept = pred_req  && run;
    assign upd_accept = upd_valid && run;
    assign pc_idx     = pred_pc[IDX_BITS+1:2];
    assign unused_pc  = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

`ifdef BPRED_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q, ghr_d;

    // Lookups always hash with the history as it stood before this cycle's update.
    assign lkp_idx = pc_idx ^ ghr_q;
    assign ghr_d   = upd_accept ? {ghr_q[IDX_BITS-2:0], upd_taken} : ghr_q;
`else
    assign lkp_idx = pc_idx;
`endif

    assign upd_cur = table_q[upd_idx];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        upd_new = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CNT_MAX) upd_new = upd_cur + 2'd1;
        end else begin
            if (upd_cur != CNT_MIN) upd_new = upd_cur - 2'd1;
        end
    end

    // Write-first: a lookup hitting the entry being trained sees the trained value.
    assign lkp_cnt = (upd_accept && (upd_idx == lkp_idx)) ? upd_new : table_q[lkp_idx];

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        tbl_we     = 1'b0;
        tbl_widx   = upd_idx;
        tbl_wdata  = upd_new;
        case (state_q)
            ST_INIT: begin
                tbl_we     = 1'b1;
                tbl_widx   = init_ptr_q;
                tbl_wdata  = CNT_WEAK_NT;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == IDX_BITS'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                tbl_we = upd_accept;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        rsp_valid_d    = lkp_accept;
        pred_taken_d   = pred_taken_q;
        pred_idx_d     = pred_idx_q;
        stat_upd_d     = stat_upd_q;
        stat_mispred_d = stat_mispred_q;
        if (lkp_accept) begin
            pred_taken_d = lkp_cnt[1];
            pred_idx_d   = lkp_idx;
        end
        if (upd_accept) begin
            if (!(&stat_upd_q)) stat_upd_d = stat_upd_q + 1'b1;
            if ((upd_taken != upd_pred) && !(&stat_mispred_q)) stat_mispred_d = stat_mispred_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            init_ptr_q     <= '0;
            rsp_valid_q    <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_idx_q     <= '0;
            stat_upd_q     <= '0;
            stat_mispred_q <= '0;
`ifdef BPRED_GSHARE_EN
            ghr_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            init_ptr_q     <= init_ptr_d;
            rsp_valid_q    <= rsp_valid_d;
            pred_taken_q   <= pred_taken_d;
            pred_idx_q     <= pred_idx_d;
            stat_upd_q     <= stat_upd_d;
            stat_mispred_q <= stat_mispred_d;
`ifdef BPRED_GSHARE_EN
            ghr_q          <= ghr_d;
`endif
        end
    end

    // NOTE: the counter array has no reset; the INIT sweep writes every entry before ready rises.
    always_ff @(posedge clk) begin
        if (tbl_we && !rst) table_q[tbl_widx] <= tbl_wdata;
    end

    assign ready          = run;
    assign pred_rsp_valid = rsp_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_idx       = pred_idx_q;
    assign stat_upd       = stat_upd_q;
    assign stat_mispred   = stat_mispred_q;

endmodule

// File: tb/tb_bpred_bht.sv
// Self-checking bench for bpred_bht: directed cases plus randomized traffic against a behavioural table model.
// A second instance with STAT_BITS=4 shares the stimulus to exercise statistics saturation.
`timescale 1ns/1ps
module tb_bpred_bht;

    localparam int IDX_BITS = 6;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic                clk = 1'b0;
    logic                rst;
    logic                pred_req;
    logic [31:0]         pred_pc;
    logic                upd_valid;
    logic [IDX_BITS-1:0] upd_idx;
    logic                upd_taken;
    logic                upd_pred;

    logic                ready, rsp_valid, taken;
    logic [IDX_BITS-1:0] idx;
    logic [15:0]         su16, sm16;
    logic                ready4, rsp_valid4, taken4;
    logic [IDX_BITS-1:0] idx4;
    logic [3:0]          su4, sm4;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int   m_cnt [ENTRIES];
    int   m_init_left;
    int   m_ghr;
    int   m_upd, m_mis;
    logic m_rsp_valid, m_taken;
    int   m_idx;

    always #5 clk = ~clk;

    bpred_bht #(.IDX_BITS(IDX_BITS), .STAT_BITS(16)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_rsp_valid(rsp_valid), .pred_taken(taken), .pred_idx(idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .stat_upd(su16), .stat_mispred(sm16)
    );

    bpred_bht #(.IDX_BITS(IDX_BITS), .STAT_BITS(4)) dut_s4 (
        .clk(clk), .rst(rst), .ready(ready4),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_rsp_valid(rsp_valid4), .pred_taken(taken4), .pred_idx(idx4),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .stat_upd(su4), .stat_mispred(sm4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic void model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 1;
        m_init_left = ENTRIES;
        m_ghr       = 0;
        m_upd       = 0;
        m_mis       = 0;
        m_rsp_valid = 1'b0;
        m_taken     = 1'b0;
        m_idx       = 0;
    endfunction

    // One clock cycle: drive inputs, advance the model, then compare all outputs after the edge.
    task automatic cycle(input logic req, input logic [31:0] pc, input logic uv,
                         input logic [IDX_BITS-1:0] uidx, input logic ut, input logic up);
        int li;
        int u;
        pred_req  = req;
        pred_pc   = pc;
        upd_valid = uv;
        upd_idx   = uidx;
        upd_taken = ut;
        upd_pred  = up;
        m_rsp_valid = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            li = int'((pc >> 2) & 32'd63) ^ m_ghr;
            if (uv) begin
                u = int'(uidx);
                m_cnt[u] = ut ? ((m_cnt[u] < 3) ? m_cnt[u] + 1 : 3)
                              : ((m_cnt[u] > 0) ? m_cnt[u] - 1 : 0);
                m_upd++;
                if (ut != up) m_mis++;
`ifdef BPRED_GSHARE_EN
                m_ghr = ((m_ghr << 1) | int'(ut)) & 63;
`endif
            end
            if (req) begin
                m_rsp_valid = 1'b1;
                m_taken     = (m_cnt[li] >= 2);
                m_idx       = li;
            end
        end
        @(posedge clk);
        #1;
        check("ready", 32'(ready), 32'(m_init_left == 0));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        check("pred_taken", 32'(taken), 32'(m_taken));
        check("pred_idx", 32'(idx), 32'(m_idx));
        check("stat_upd", 32'(su16), 32'(sat(m_upd, 65535)));
        check("stat_mispred", 32'(sm16), 32'(sat(m_mis, 65535)));
        check("stat_upd_w4", 32'(su4), 32'(sat(m_upd, 15)));
        check("stat_mispred_w4", 32'(sm4), 32'(sat(m_mis, 15)));
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic train(input logic [IDX_BITS-1:0] i, input logic t, input logic p);
        cycle(1'b0, 32'h0, 1'b1, i, t, p);
    endtask

    task automatic lookup(input logic [31:0] pc);
        cycle(1'b1, pc, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] pc;
        rst = 1'b1;
        pred_req = 1'b0; pred_pc = '0; upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_pred = 1'b0;
        repeat (3) idle();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_pred_idx", 32'(idx), 32'd0);

        // Init timing
        rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            idle();
            n++;
        end
        check("init_cycles", 32'(n), 32'd64);
        lookup(32'h0000_0100);
        check("first_lookup_taken", 32'(taken), 32'd0);

`ifdef BPRED_GSHARE_EN
        // A taken outcome shifts into the history; PC 0x0 then hashes to index 1.
        train(6'd1, 1'b1, 1'b0);
        lookup(32'h0000_0000);
        check("gshare_idx", 32'(idx), 32'd1);
        check("gshare_taken", 32'(taken), 32'd1);
`else
        repeat (3) train(6'd5, 1'b1, 1'b0);
        lookup(32'h0000_0014);
        check("idx5_trained", 32'(taken), 32'd1);
        train(6'd5, 1'b1, 1'b1);
        train(6'd5, 1'b0, 1'b1);
        lookup(32'h0000_0014);
        check("idx5_after_sat", 32'(taken), 32'd1);

        repeat (2) train(6'd9, 1'b0, 1'b0);
        train(6'd9, 1'b1, 1'b0);
        lookup(32'h0000_0024);
        check("idx9_low_sat", 32'(taken), 32'd0);

        cycle(1'b1, 32'h0000_000C, 1'b1, 6'd3, 1'b1, 1'b0);
        check("collision_taken", 32'(taken), 32'd1);
        check("collision_idx", 32'(idx), 32'd3);
`endif

        // Reset during RUN with a trained table
        rst = 1'b1;
        idle();
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_stat_upd", 32'(su16), 32'd0);
        check("midrst_stat_mispred", 32'(sm16), 32'd0);
        rst = 1'b0;
        repeat (64) idle();
        check("midrst_ready_back", 32'(ready), 32'd1);
        for (int i = 0; i < ENTRIES; i++) begin
            lookup(32'(i) << 2);
            check("midrst_all_nt", 32'(taken), 32'd0);
        end

        // Statistics: ten updates, four mispredicted, then saturation of the 4-bit instance
        for (int i = 0; i < 10; i++) begin
            logic t;
            t = logic'(i % 2);
            train(6'(i), t, (i < 4) ? ~t : t);
        end
        check("stats10_upd", 32'(su16), 32'd10);
        check("stats10_mispred", 32'(sm16), 32'd4);
        for (int i = 0; i < 10; i++) train(6'(i + 20), 1'b1, 1'b1);
        check("stats20_upd", 32'(su16), 32'd20);
        check("stats20_upd_w4_sat", 32'(su4), 32'd15);
        check("stats20_mispred_w4", 32'(sm4), 32'd4);

        // Randomized traffic; narrow index ranges make same-index collisions frequent
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            pc = $urandom;
            pc[7:2] = 6'($urandom_range(0, 15));
            cycle($urandom_range(0, 9) < 6, pc, $urandom_range(0, 1) == 1,
                  6'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        end
        rst = 1'b0;
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
